op_imm_encoder: RTL and testbench
=================================

OP_IMM_ENCODER -- requirements
Module: op_imm_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-007 instr_id  input  `INST_ID_LEN  instruction ID (ADDI_ID..SRAI_ID, the shared ID encoding).
REQ-008 rd, rs1  input  5 each  destination / source register index.
REQ-009 imm  input  12  immediate; for shifts, imm[4:0]=shamt.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  consumer takes word when high with out_valid.
REQ-012 out_inst  output  32  encoded RV32I OP-IMM instruction.
REQ-013 err  output  1  one-cycle pulse: accepted request was illegal and dropped.

Function
REQ-014 Handshake: transfer on in_valid&&in_ready; in_ready = (count < DEPTH); in_ready SHALL NOT depend on out_ready.
REQ-015 Encoding: out_inst = {imm[11:0], rs1, funct3, rd, 7'b0010011} for ADDI(000), SLTI(010), SLTIU(011), XORI(100), ORI(110), ANDI(111).
REQ-016 Shifts: out_inst = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011}; SLLI funct3 001/funct7 0000000, SRLI 101/0000000, SRAI 101/0100000.
REQ-017 Illegal: instr_id not an OP-IMM ID (incl. NONE_ID), or shift with imm[11:5] != 0 -> request accepted, not pushed, err high the following cycle.
REQ-018 Latency: legal request accepted in cycle N with FIFO empty -> out_valid high, out_inst valid in cycle N+1; no combinational in->out path.
REQ-019 FIFO: in-order, count 0..DEPTH, read/write pointers wrap modulo DEPTH.
REQ-020 Output held stable (out_inst unchanged, out_valid high) until out_ready seen.
REQ-021 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both complete.
REQ-022 Full (count==DEPTH): in_ready low; pop in same cycle frees slot, in_ready high next cycle.
REQ-023 Empty: out_valid low; out_inst value don't-care but SHALL NOT be X after reset.
REQ-024 Illegal request with simultaneous pop: pop completes, count decrements, err pulses.

Reset
REQ-025 rst_n low SHALL immediately clear count, pointers, out_valid=0, err=0, out_inst=32'h0000_0013 (NOP), in_ready=1 once released.
REQ-026 Reset mid-operation SHALL discard all buffered words; no output after release until a new legal request.

Configuration
REQ-027 OP_IMM_ENC_ERRCNT_EN defined: add output err_cnt (8 bits), incremented on each err pulse, saturating at 8'hFF, reset to 0.
REQ-028 OP_IMM_ENC_ERRCNT_EN undefined: no err_cnt port or counter logic; all other behaviour identical.

Structure
REQ-029 OP-IMM opcode, funct3 and funct7 constants and the instruction-ID codes SHALL come from the shared defines package, also used by the decoder; no local literals for them.
REQ-030 Encoding SHALL be a combinational function/block in this module; FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH).

Verification
REQ-031 ADDI rd=1 rs1=2 imm=12'h005 in empty FIFO, out_ready=1 -> next cycle out_inst=32'h00510093, out_valid=1.
REQ-032 SRAI rd=3 rs1=4 imm=12'h003 -> 32'h40325193; SLLI imm=12'h021 -> dropped, err pulse, no out_valid.
REQ-033 out_ready=0, 5 legal requests, DEPTH=4 -> 4 accepted, in_ready low; raise out_ready -> 4 words in order, then 5th.
REQ-034 Continuous in_valid and out_ready, 100 random legal requests -> throughput 1/cycle, order and encodings match decoder round-trip.
REQ-035 rst_n asserted with 3 words buffered -> out_valid=0 immediately, out_inst=32'h00000013, no stale words after release.
REQ-036 With OP_IMM_ENC_ERRCNT_EN: 300 illegal requests -> err_cnt=8'hFF, holds.

Source files
------------

// File: rtl/op_imm_encoder_pkg.sv
// ============================================================================
// Module      : op_imm_encoder_pkg
// Description : Shared RV32I defines: instruction-ID codes (also used by the
//               decoder), OP-IMM opcode, funct3/funct7 constants, NOP word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package op_imm_encoder_pkg;

  // Width of the shared instruction-ID encoding
  localparam int INST_ID_LEN = 6;

  // Shared instruction-ID codes (OP-IMM subset plus neighbours the decoder uses)
  localparam logic [INST_ID_LEN-1:0] NONE_ID  = 6'd0;
  localparam logic [INST_ID_LEN-1:0] ADDI_ID  = 6'd1;
  localparam logic [INST_ID_LEN-1:0] SLTI_ID  = 6'd2;
  localparam logic [INST_ID_LEN-1:0] SLTIU_ID = 6'd3;
  localparam logic [INST_ID_LEN-1:0] XORI_ID  = 6'd4;
  localparam logic [INST_ID_LEN-1:0] ORI_ID   = 6'd5;
  localparam logic [INST_ID_LEN-1:0] ANDI_ID  = 6'd6;
  localparam logic [INST_ID_LEN-1:0] SLLI_ID  = 6'd7;
  localparam logic [INST_ID_LEN-1:0] SRLI_ID  = 6'd8;
  localparam logic [INST_ID_LEN-1:0] SRAI_ID  = 6'd9;
  localparam logic [INST_ID_LEN-1:0] ADD_ID   = 6'd10;
  localparam logic [INST_ID_LEN-1:0] SUB_ID   = 6'd11;
  localparam logic [INST_ID_LEN-1:0] LW_ID    = 6'd12;
  localparam logic [INST_ID_LEN-1:0] SW_ID    = 6'd13;

  // OP-IMM major opcode
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // OP-IMM funct3 field values
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  // Shift funct7 field values
  localparam logic [6:0] F7_SLLI = 7'b0000000;
  localparam logic [6:0] F7_SRLI = 7'b0000000;
  localparam logic [6:0] F7_SRAI = 7'b0100000;

  // Canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Result of encoding one request
  typedef struct packed {
    logic        legal;
    logic [31:0] inst;
  } enc_result_t;

endpackage : op_imm_encoder_pkg

`default_nettype wire

// File: rtl/op_imm_encoder_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock valid/ready FIFO, DEPTH entries of WIDTH bits.
//               Head word presented combinationally from storage; pointers
//               wrap modulo DEPTH; async active-low reset of control state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  // Ready depends only on occupancy, never on the read side
  assign wr_ready_o = (count_q < FULL_CNT);
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rptr_q];

  assign do_wr = wr_valid_i && wr_ready_o;
  assign do_rd = rd_ready_i && rd_valid_o;

  // Next pointers and occupancy; simultaneous write and read leave count unchanged
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_wr) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + AW'(1);
    end
    if (do_rd) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/op_imm_encoder.sv
// ============================================================================
// Module      : op_imm_encoder
// Description : Encodes OP-IMM requests (instruction ID + fields) into RV32I
//               words, buffered through a sync_fifo. Illegal requests are
//               accepted, dropped and flagged by a one-cycle err pulse.
//               Optional macro OP_IMM_ENC_ERRCNT_EN adds a saturating 8-bit
//               err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_imm_encoder
  import op_imm_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_ID_LEN-1:0] instr_id,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [11:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic                   err
`ifdef OP_IMM_ENC_ERRCNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  // Build the RV32I word for one request and flag whether it is legal
  function automatic enc_result_t encode_op_imm(
    input logic [INST_ID_LEN-1:0] id,
    input logic [4:0]             rd_f,
    input logic [4:0]             rs1_f,
    input logic [11:0]            imm_f
  );
    enc_result_t r;
    r.legal = 1'b1;
    r.inst  = NOP_INST;
    case (id)
      ADDI_ID:  r.inst = {imm_f, rs1_f, F3_ADDI,  rd_f, OPC_OP_IMM};
      SLTI_ID:  r.inst = {imm_f, rs1_f, F3_SLTI,  rd_f, OPC_OP_IMM};
      SLTIU_ID: r.inst = {imm_f, rs1_f, F3_SLTIU, rd_f, OPC_OP_IMM};
      XORI_ID:  r.inst = {imm_f, rs1_f, F3_XORI,  rd_f, OPC_OP_IMM};
      ORI_ID:   r.inst = {imm_f, rs1_f, F3_ORI,   rd_f, OPC_OP_IMM};
      ANDI_ID:  r.inst = {imm_f, rs1_f, F3_ANDI,  rd_f, OPC_OP_IMM};
      // Shifts: upper immediate bits must be zero, funct7 comes from the ID
      SLLI_ID: begin
        r.inst  = {F7_SLLI, imm_f[4:0], rs1_f, F3_SLLI, rd_f, OPC_OP_IMM};
        r.legal = (imm_f[11:5] == 7'd0);
      end
      SRLI_ID: begin
        r.inst  = {F7_SRLI, imm_f[4:0], rs1_f, F3_SRXI, rd_f, OPC_OP_IMM};
        r.legal = (imm_f[11:5] == 7'd0);
      end
      SRAI_ID: begin
        r.inst  = {F7_SRAI, imm_f[4:0], rs1_f, F3_SRXI, rd_f, OPC_OP_IMM};
        r.legal = (imm_f[11:5] == 7'd0);
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  enc_result_t enc;
  logic        accept;
  logic        push;
  logic        err_d;
  logic        err_q;
  logic        fifo_wr_ready;
  logic        fifo_rd_valid;
  logic [31:0] fifo_rd_data;

  // Combinational encode of the request currently on the input
  always_comb begin
    enc = encode_op_imm(instr_id, rd, rs1, imm);
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && enc.legal;
  assign err_d  = accept && !enc.legal;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (push),
    .wr_ready_o (fifo_wr_ready),
    .wr_data_i  (enc.inst),
    .rd_valid_o (fifo_rd_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (fifo_rd_data)
  );

  assign in_ready  = fifo_wr_ready;
  assign out_valid = fifo_rd_valid;
  // Show a NOP while empty so the output is never X after reset
  assign out_inst  = fifo_rd_valid ? fifo_rd_data : NOP_INST;
  assign err       = err_q;

  // Error pulse register: one cycle after an illegal request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifdef OP_IMM_ENC_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  // Saturating count of err pulses
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule : op_imm_encoder

`default_nettype wire

// File: tb/tb_op_imm_encoder.sv
// ============================================================================
// Module      : tb_op_imm_encoder
// Description : Scoreboard bench for op_imm_encoder. Driver pushes expected
//               words on acceptance; a negedge monitor pops and compares on
//               every output handshake. Honours OP_IMM_ENC_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_op_imm_encoder;
  import op_imm_encoder_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [INST_ID_LEN-1:0] instr_id;
  logic [4:0]             rd;
  logic [4:0]             rs1;
  logic [11:0]            imm;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_inst;
  logic                   err;
`ifdef OP_IMM_ENC_ERRCNT_EN
  logic [7:0]             err_cnt;
`endif

  int          n_vec    = 0;
  int          n_fail   = 0;
  int          exp_err  = 0;
  int          err_seen = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  op_imm_encoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_id  (instr_id),
    .rd        (rd),
    .rs1       (rs1),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .err       (err)
`ifdef OP_IMM_ENC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // Reference encoder built from the RV32I field layout
  function automatic logic [31:0] ref_word(input logic [5:0] id, input logic [4:0] d,
                                           input logic [4:0] s, input logic [11:0] im);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       sh;
    f3 = 3'd0; f7 = 7'd0; sh = 1'b0;
    if (id == SLTI_ID)       f3 = 3'd2;
    else if (id == SLTIU_ID) f3 = 3'd3;
    else if (id == XORI_ID)  f3 = 3'd4;
    else if (id == ORI_ID)   f3 = 3'd6;
    else if (id == ANDI_ID)  f3 = 3'd7;
    else if (id == SLLI_ID) begin f3 = 3'd1; sh = 1'b1; end
    else if (id == SRLI_ID) begin f3 = 3'd5; sh = 1'b1; end
    else if (id == SRAI_ID) begin f3 = 3'd5; sh = 1'b1; f7 = 7'h20; end
    return sh ? {f7, im[4:0], s, f3, d, 7'h13} : {im, s, f3, d, 7'h13};
  endfunction

  function automatic logic ref_legal(input logic [5:0] id, input logic [11:0] im);
    if (id >= 6'd7 && id <= 6'd9) return (im[11:5] == 7'd0);
    return (id >= 6'd1 && id <= 6'd6);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake and count err pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (err === 1'b1) err_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", out_inst);
        end else begin
          check("word", out_inst, exp_q.pop_front());
        end
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [5:0] id, input logic [4:0] d, input logic [4:0] s,
                      input logic [11:0] im);
    int w;
    instr_id = id; rd = d; rs1 = s; imm = im; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      if (ref_legal(id, im)) exp_q.push_back(ref_word(id, d, s, im));
      else exp_err++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] held;
  int          c0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_id = NONE_ID; rd = 5'd0; rs1 = 5'd0; imm = 12'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI latency and encoding
    out_ready = 1'b1;
    send(ADDI_ID, 5'd1, 5'd2, 12'h005);
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_inst", out_inst, 32'h0051_0093);

    // SRAI encoding
    send(SRAI_ID, 5'd3, 5'd4, 12'h003);
    check("srai_inst", out_inst, 32'h4032_5193);

    // SLLI with nonzero upper immediate is dropped
    send(SLLI_ID, 5'd3, 5'd4, 12'h021);
    check("slli_bad_err", {31'd0, err}, 32'd1);
    check("slli_bad_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("err_one_cycle", {31'd0, err}, 32'd0);

    // ORI with all-ones immediate
    send(ORI_ID, 5'd5, 5'd6, 12'hFFF);
    check("ori_inst", out_inst, 32'hFFF3_6293);

    // Further illegal IDs and an illegal SRAI, mixed with legal words
    send(NONE_ID, 5'd1, 5'd1, 12'h000);
    send(ADD_ID, 5'd1, 5'd1, 12'h000);
    send(SRAI_ID, 5'd1, 5'd1, 12'h403);
    send(ANDI_ID, 5'd31, 5'd31, 12'h800);
    send(SRLI_ID, 5'd7, 5'd8, 12'h01F);
    send(SLTIU_ID, 5'd9, 5'd10, 12'h7FF);
    drain();

    // Backpressure: fill, hold stable, then release with a fifth request pending
    out_ready = 1'b0;
    send(XORI_ID, 5'd1, 5'd2, 12'h111);
    send(SLTI_ID, 5'd3, 5'd4, 12'h222);
    send(ADDI_ID, 5'd5, 5'd6, 12'h333);
    send(SLLI_ID, 5'd7, 5'd8, 12'h004);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    held = out_inst;
    check("full_head", held, ref_word(XORI_ID, 5'd1, 5'd2, 12'h111));
    fork
      send(ANDI_ID, 5'd9, 5'd10, 12'h444);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("stall_stable", out_inst, held);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: back-to-back random legal requests at one per cycle
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      logic [5:0]  id;
      logic [11:0] im;
      id = 6'($urandom_range(1, 9));
      im = 12'($urandom);
      if (id >= 6'd7) im[11:5] = 7'd0;
      send(id, 5'($urandom), 5'($urandom), im);
    end
    check("throughput_cycles", cyc - c0, 32'd100);
    drain();

    // Illegal request while a pop completes
    out_ready = 1'b0;
    send(ADDI_ID, 5'd2, 5'd3, 12'h00A);
    send(ORI_ID, 5'd4, 5'd5, 12'h00B);
    out_ready = 1'b1;
    send(LW_ID, 5'd1, 5'd1, 12'h000);
    check("ill_pop_err", {31'd0, err}, 32'd1);
    drain();

    // Reset with words buffered discards them
    out_ready = 1'b0;
    send(ADDI_ID, 5'd1, 5'd1, 12'h001);
    send(ADDI_ID, 5'd2, 5'd2, 12'h002);
    send(ADDI_ID, 5'd3, 5'd3, 12'h003);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_inst", out_inst, 32'h0000_0013);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("postrst_valid", {31'd0, out_valid}, 32'd0);
    send(XORI_ID, 5'd11, 5'd12, 12'hABC);
    check("postrst_inst", out_inst, 32'hABC6_4593);
    drain();

`ifdef OP_IMM_ENC_ERRCNT_EN
    // Error counter saturates
    for (int i = 0; i < 300; i++) send(SW_ID, 5'd0, 5'd0, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    check("err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    check("err_pulses", err_seen, exp_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_op_imm_encoder

`default_nettype wire
